// File: rtl/ud_bcd_counter_n.sv
// rtl/ud_bcd_counter_n.sv - parametrised multi-digit up/down BCD counter with load, saturation and terminal count
module ud_bcd_counter_n #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  x,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  err
);

    logic [4*DIGITS-1:0] r_q;
    logic                r_err;

    logic [4*DIGITS-1:0] w_count_next;
    logic [4*DIGITS-1:0] w_load_val;
    logic                w_load_bad;
    logic                w_at_limit;
    logic                w_step;
    logic [3:0]          w_digit;
    logic [3:0]          w_ld_digit;

    // Ripple the increment/decrement through the digits: a digit steps only
    // while every lower digit sits at its limit (9 going up, 0 going down).
    // The chain surviving past the top digit means the whole count is at the limit.
    always_comb begin
        w_count_next = r_q;
        w_step       = 1'b1;
        w_digit      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_q[4*i +: 4];
            if (w_step) begin
                if (!x) begin
                    w_count_next[4*i +: 4] = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
                end else begin
                    w_count_next[4*i +: 4] = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
                end
            end
            w_step = w_step & (x ? (w_digit == 4'd0) : (w_digit == 4'd9));
        end
        w_at_limit = w_step;
    end

    // Sanitise load data: non-BCD digits are written as zero and flagged.
    always_comb begin
        w_load_val = '0;
        w_load_bad = 1'b0;
        w_ld_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_ld_digit = din[4*i +: 4];
            if (w_ld_digit > 4'd9) begin
                w_load_bad = 1'b1;
            end else begin
                w_load_val[4*i +: 4] = w_ld_digit;
            end
        end
    end

    // Count register: load beats enable; in saturating mode the count freezes at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_err <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_val;
            r_err <= w_load_bad;
        end else if (en) begin
            if (!(SATURATE && w_at_limit)) begin
                r_q <= w_count_next;
            end
        end
    end

    assign q   = r_q;
    assign err = r_err;
    assign tc  = en & ~load & w_at_limit;

endmodule

// File: tb/tb_ud_bcd_counter_n.sv
// tb/tb_ud_bcd_counter_n.sv - randomized and directed bench for ud_bcd_counter_n against an integer model
module tb_ud_bcd_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] q_w, q_s;
    logic       tc_w, tc_s, err_w, err_s;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, err_lo, err_hi;

    int n_tests = 0;
    int n_fail  = 0;

    int m_w   = 0;
    int m_s   = 0;
    int m_err = 0;

    always #5 clk = ~clk;

    ud_bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din),
        .q(q_w), .tc(tc_w), .err(err_w)
    );

    ud_bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din),
        .q(q_s), .tc(tc_s), .err(err_s)
    );

    ud_bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[3:0]),
        .q(q_lo), .tc(tc_lo), .err(err_lo)
    );

    ud_bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .x(x), .load(load), .din(din[7:4]),
        .q(q_hi), .tc(tc_hi), .err(err_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic exp_tc(input int v);
        return en & ~load & (x ? (v == 0) : (v == 99));
    endfunction

    task automatic model_reset();
        m_w   = 0;
        m_s   = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input logic e, input logic xx, input logic ld, input logic [7:0] d);
        int hi;
        int lo;
        if (ld) begin
            hi    = int'(d[7:4]);
            lo    = int'(d[3:0]);
            m_err = (hi > 9 || lo > 9) ? 1 : 0;
            if (hi > 9) hi = 0;
            if (lo > 9) lo = 0;
            m_w = hi * 10 + lo;
            m_s = m_w;
        end else if (e) begin
            if (!xx) begin
                m_w = (m_w + 1) % 100;
                m_s = (m_s == 99) ? 99 : m_s + 1;
            end else begin
                m_w = (m_w + 99) % 100;
                m_s = (m_s == 0) ? 0 : m_s - 1;
            end
        end
    endtask

    task automatic check_all();
        check("q_wrap", 32'(q_w), 32'(to_bcd(m_w)));
        check("q_sat", 32'(q_s), 32'(to_bcd(m_s)));
        check("q_cascade", 32'({q_hi, q_lo}), 32'(to_bcd(m_w)));
        check("err_wrap", 32'(err_w), 32'(m_err));
        check("err_sat", 32'(err_s), 32'(m_err));
        check("err_cascade", 32'(err_hi | err_lo), 32'(m_err));
        check("tc_wrap", 32'(tc_w), 32'(exp_tc(m_w)));
        check("tc_sat", 32'(tc_s), 32'(exp_tc(m_s)));
        check("tc_cascade", 32'(tc_hi), 32'(exp_tc(m_w)));
    endtask

    // Apply one cycle of inputs: check the pre-edge state and tc, then clock the model.
    task automatic cycle(input logic e, input logic xx, input logic ld, input logic [7:0] d);
        en   = e;
        x    = xx;
        load = ld;
        din  = d;
        #1;
        check_all();
        @(posedge clk);
        model_edge(e, xx, ld, d);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        model_reset();
        #12;
        check("reset_q", 32'(q_w), 32'h00);
        check("reset_err", 32'(err_w), 32'h0);
        check("reset_tc", 32'(tc_w), 32'h0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Up count through a full wrap
        for (int i = 0; i < 101; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("up_wrap_q", 32'(q_w), 32'h01);

        // Down count from zero
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        en = 1'b1; x = 1'b1; load = 1'b0; #1;
        check("down_tc_at_00", 32'(tc_w), 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("down_q", 32'(q_w), 32'h95);
        cycle(1'b0, 1'b0, 1'b1, 8'h10);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("borrow_q", 32'(q_w), 32'h09);

        // Load handling
        cycle(1'b0, 1'b0, 1'b1, 8'h3A);
        check("load_3a_q", 32'(q_w), 32'h30);
        check("load_3a_err", 32'(err_w), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 8'h42);
        check("load_42_q", 32'(q_w), 32'h42);
        check("load_42_err", 32'(err_w), 32'h0);
        en = 1'b1; load = 1'b1; din = 8'h55; #1;
        check("load_en_tc", 32'(tc_w), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'h55);
        check("load_en_q", 32'(q_w), 32'h55);

        // Saturation
        cycle(1'b0, 1'b0, 1'b1, 8'h98);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_hold_q", 32'(q_s), 32'h99);
        check("sat_tc", 32'(tc_s), 32'h1);
        en = 1'b1; x = 1'b1; load = 1'b0; #1;
        check("sat_tc_drop", 32'(tc_s), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("sat_down_q", 32'(q_s), 32'h98);

        // Direction toggling, then hold
        cycle(1'b0, 1'b0, 1'b1, 8'h19);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("toggle_1", 32'(q_w), 32'h20);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("toggle_2", 32'(q_w), 32'h19);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("toggle_3", 32'(q_w), 32'h20);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        check("toggle_4", 32'(q_w), 32'h19);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("hold_q", 32'(q_w), 32'h19);

        // Asynchronous reset mid-count with err set
        cycle(1'b0, 1'b0, 1'b1, 8'h4A);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("pre_rst_q", 32'(q_w), 32'h47);
        check("pre_rst_err", 32'(err_w), 32'h1);
        en = 1'b1; x = 1'b0; load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_q", 32'(q_w), 32'h00);
        check("async_rst_err", 32'(err_w), 32'h0);
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b1, 1'b0, 1'b0, 8'h00);
        check("resume_q", 32'(q_w), 32'h01);

        // Randomized traffic, cascade against the two-digit instance and the model
        for (int i = 0; i < 250; i++) begin
            logic       r_en;
            logic       r_x;
            logic       r_ld;
            logic [7:0] r_d;
            r_en = 1'($urandom_range(0, 3) != 0);
            r_x  = 1'($urandom_range(0, 1));
            r_ld = 1'($urandom_range(0, 15) == 0);
            r_d  = 8'($urandom);
            cycle(r_en, r_x, r_ld, r_d);
        end
        #1;
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ud_bcd_counter_n.md
# ud_bcd_counter_n

Parametrised multi-digit up/down BCD counter. It is the successor to the single-digit JK-based up/down BCD counter and is used for decimal event and display counters. The block chains DIGITS BCD digits with internal carry/borrow propagation. It adds synchronous parallel load, count enable, a terminal-count output for cascading, optional saturation instead of wrap-around, and detection of invalid (non-BCD) load data.

## Interface
- DIGITS, 4, number of BCD digits (legal range 1..8); counter width is 4*DIGITS bits.
- SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- x  input  1  direction: 0 = count up, 1 = count down.
- load  input  1  synchronous parallel load; takes priority over en.
- din  input  4*DIGITS  load value; digit i is din[4i+3:4i], with digit 0 least significant.
- q  output  4*DIGITS  registered count, same digit packing as din.
- tc  output  1  terminal count (combinational): en & ~load & at limit for the current x.
- err  output  1  registered flag indicating that the last load contained a non-BCD digit.

## Operation
- Reset (rst=0, any time, independent of clk):
  - q = 0.
  - err = 0.
  - Consequently tc = 0 whenever en=0.
- Priority per rising edge is load, then en, then hold.
- Load behaviour:
  - Each digit of din with value ≤ 9 is copied to q.
  - Each digit with value 10..15 is written as 0.
  - err is set to 1 if any digit was > 9, otherwise it is cleared to 0.
  - err changes only on a load or on reset.
- Count up (en=1, x=0):
  - Digit 0 increments.
  - Digit i increments only when every lower digit equals 9.
  - A digit at 9 that increments becomes 0.
- Count down (en=1, x=1):
  - Digit 0 decrements.
  - Digit i decrements only when every lower digit equals 0.
  - A digit at 0 that decrements becomes 9.
- Limits:
  - The up limit is all digits = 9 (the value 10^DIGITS − 1).
  - The down limit is all digits = 0.
- At a limit with SATURATE=0:
  - The counter wraps: 9..9 → 0..0 going up, and 0..0 → 9..9 going down.
  - tc=1 during the cycle before the wrapping edge.
- At a limit with SATURATE=1:
  - q holds at the limit.
  - tc remains 1 for as long as en=1 and the direction points at the limit.
- Changing direction:
  - x may change on any cycle.
  - The new direction applies on the next enabled edge, with no lost or double counts.
  - tc re-evaluates immediately.
- Digits of q are always in the range 0..9; no reachable state has a non-BCD digit.
- Cascading: tc of one instance drives en of the next, more significant instance, with the same x and clk.

## Timing
- q has a latency of 1 cycle from an enabled or load edge. q is registered with no combinational path from inputs.
- err is updated on the same edge as the load.
- tc is combinational from q, en, load and x. It is valid in the same cycle and settles before the next edge.
- Asynchronous reset:
  - Assertion clears q and err immediately.
  - Deassertion is expected clear of the clk edge; the first count or load can occur on the first edge after deassertion.
- Reset asserted during a load or count cycle: the reset wins and no partial update is visible.
- Throughput is one count per cycle with no bubbles.

## Test plan
- DIGITS=2, SATURATE=0:
  - Reset, then en=1, x=0 for 100 cycles.
  - Required: q goes 00, 01, … 99, then 00.
  - Required: tc=1 only in the cycle where q=99.
  - Required: digit 1 increments exactly when digit 0 wraps from 9 to 0.
- DIGITS=2, SATURATE=0, down count:
  - Reset, en=1, x=1.
  - Required: q goes 00 → 99 → 98 …, and tc=1 in the cycle where q=00.
  - Load 0x10, then one down edge: required q=0x09.
- DIGITS=2, load handling:
  - Load din=0x3A: required q=0x30, err=1.
  - Then load 0x42: required q=0x42, err=0.
  - Assert load and en together with din=0x55: required q=0x55, no count applied, tc=0.
- DIGITS=2, SATURATE=1:
  - Load 0x98, then up for 3 cycles: required q=0x99, 0x99, 0x99, with tc=1 from the cycle q=0x99 onward.
  - Switch x=1: required tc drops to 0 immediately and the next edge gives q=0x98.
- Direction toggling:
  - From q=0x19, apply x = 0, 1, 0, 1 on consecutive enabled edges.
  - Required q: 0x20, 0x19, 0x20, 0x19.
  - Hold en=0 for 5 cycles: required q unchanged.
- Reset mid-operation:
  - While counting at q=0x47 with en=1, pulse rst low between clk edges.
  - Required: q=0x00 and err=0 immediately without waiting for a clk edge, and counting resumes from 0x00 after release.
- Cascade: two DIGITS=1 instances linked through tc → en must match a DIGITS=2 instance cycle for cycle over 250 random x/en cycles.
